tick_gated_fifo: RTL
====================

Name: tick_gated_fifo

Overview:
- Single-clock FIFO sitting directly downstream of the clock divider.
- The divider's write-rate and read-rate outputs are converted to one-cycle strobes (wr_tick, rd_tick) in the clk domain and qualify every write and read here.
- This gives a rate-mismatched producer/consumer buffer without a second clock domain.
- Provides full/empty, almost flags, occupancy and sticky overflow/underflow error reporting.

Parameters:
- DATA_W, 8, data word width in bits.
- DEPTH, 8, number of entries; power of two, at least 4.
- AW, log2(DEPTH), address width; derived, not overridden.
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_tick  input  1  write-rate strobe, one clk cycle wide.
- wr_en  input  1  producer requests a write.
- wr_data  input  DATA_W  write data.
- rd_tick  input  1  read-rate strobe, one clk cycle wide.
- rd_en  input  1  consumer requests a read.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  one-cycle pulse: rd_data holds a newly read word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky write-rejected error.
- underflow  output  1  sticky read-rejected error.
- clr_err  input  1  clears overflow/underflow.

Behaviour:
- Reset, sampled on rising clk edge, values:
  - count=0, empty=1, full=0, almost_empty=1, almost_full=0.
  - rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - wr/rd pointers=0. Storage array is not reset.
- Write attempt = wr_tick & wr_en. Accepted iff attempt & !full.
  - On accept: mem[wr_ptr] <= wr_data, wr_ptr increments modulo DEPTH.
- Read attempt = rd_tick & rd_en. Accepted iff attempt & !empty.
  - On accept: rd_data <= mem[rd_ptr], rd_ptr increments modulo DEPTH.
  - rd_valid = 1 in the following cycle only.
- Flag timing and latency:
  - full/empty evaluate the state at the start of the cycle, never the same-cycle opposite operation.
  - Read latency is 1 cycle from accepted read to rd_valid/rd_data.
  - No fall-through: a word written in cycle N is readable at the earliest in cycle N+1.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
- Write attempt while full: rejected even if a read is accepted the same cycle; overflow <= 1.
- Read attempt while empty: rejected even if a write is accepted the same cycle; underflow <= 1. rd_data holds, rd_valid=0.
- Attempts without the matching tick are ignored: no state change, no error.
- rd_data holds its last value between accepted reads.
- count arithmetic:
  - +1 on write-only accept, -1 on read-only accept, else unchanged.
  - Never exceeds DEPTH, never below 0.
- Status outputs full, empty, almost_full, almost_empty are registered (or derived combinationally from registered count); all are consistent with count in the same cycle.
- Pointer wrap: DEPTH-1 -> 0 with no disturbance to count or flags.
- Error flags:
  - clr_err clears both flags next cycle.
  - If an error event coincides with clr_err, the flag is set (the event wins).
- Reset mid-operation returns everything to reset values next cycle; an in-flight rd_valid is suppressed.

Test Plan:
- Reset, then idle 5 cycles -> empty=1, count=0, rd_valid=0, rd_data=0, overflow=underflow=0.
- Write 0x11..0x18 with wr_tick every 2nd cycle and rd_en=0 (DEPTH=8) -> count goes 1..8; almost_full at count 6; full at 8. Then read all 8 with rd_tick every 3rd cycle -> rd_data 0x11..0x18 in order, each with a 1-cycle rd_valid; empty at end.
- While full, assert wr_tick&wr_en with 0xAA together with an accepted read -> read returns oldest word, count=7, overflow=1, 0xAA never appears on later reads.
- While empty, assert rd_tick&rd_en and write 0x5C the same cycle -> rd_valid stays 0, underflow=1, count=1. Next read tick -> rd_data=0x5C.
- Keep ~4 entries with concurrent write/read for 20 accepted pairs -> pointers wrap twice, count stays constant, data order preserved. wr_en high without wr_tick adds nothing.
- Fill to 5, assert reset for 1 cycle during an accepted read -> rd_valid=0 next cycle, count=0, empty=1. Then set overflow, assert clr_err -> overflow=0 next cycle. clr_err coincident with a new overflow -> overflow=1.

Source files
------------

// File: rtl/tick_gated_fifo.sv
// Single-clock FIFO whose writes and reads are qualified by one-cycle rate strobes.
// Provides occupancy, full/empty, almost flags and sticky overflow/underflow errors.
module tick_gated_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_tick,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_tick,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam logic [AW:0] LP_DEPTH  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_AFULL  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] LP_AEMPTY = (AW+1)'(AEMPTY_TH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_attempt;
    logic w_rd_attempt;
    logic w_wr_accept;
    logic w_rd_accept;

    // Flags come from the registered count, so they reflect start-of-cycle state only.
    assign w_full       = (r_count == LP_DEPTH);
    assign w_empty      = (r_count == '0);
    assign w_wr_attempt = wr_tick & wr_en;
    assign w_rd_attempt = rd_tick & rd_en;
    assign w_wr_accept  = w_wr_attempt & ~w_full;
    assign w_rd_accept  = w_rd_attempt & ~w_empty;

    // NOTE: storage has no reset; pointers and count alone define which words are valid.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            unique case ({w_wr_accept, w_rd_accept})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A rejected attempt in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_attempt && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_rd_attempt && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= LP_AFULL);
    assign almost_empty = (r_count <= LP_AEMPTY);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
